// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a stable synchronised lock,
// then releases the core reset. It re-initialises the PLL on lock loss, timeout or request.
`timescale 1ns/1ps
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned CNT_W         = 17
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       pll_reset_req,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic [7:0] relock_count,
  output logic       timeout_err
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q;
  logic             locked_s;
  logic             cnt_clr;
  logic             relock_inc;
  logic             timeout_set;

  // Two-flop synchroniser for the asynchronous lock flag
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], locked};
  end

  assign locked_s = sync_q[1];

  // Next-state logic; an explicit re-init request outranks timeout and lock loss
  always_comb begin
    state_d     = state_q;
    cnt_clr     = 1'b0;
    relock_inc  = 1'b0;
    timeout_set = 1'b0;
    if (pll_reset_req) begin
      state_d = PLL_RST;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABLE;
          end else if (cnt_q == TO_LAST) begin
            state_d     = PLL_RST;
            timeout_set = 1'b1;
          end
        end
        STABLE: begin
          if (!locked_s)                 state_d = WAIT_LOCK;
          else if (cnt_q == STABLE_LAST) state_d = RUN;
        end
        RUN: begin
          if (!locked_s) begin
            state_d    = PLL_RST;
            relock_inc = 1'b1;
          end
        end
        default: state_d = PLL_RST;
      endcase
    end
    if (state_d != state_q) cnt_clr = 1'b1;
    // Counter holds at full scale rather than wrapping during a long RUN
    if (cnt_clr)               cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + CNT_W'(1);
  end

  // State, counter and Moore outputs all registered on the same edge
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      pll_rst      <= 1'b1;
      sys_reset    <= 1'b1;
      ready        <= 1'b0;
      relock_count <= 8'd0;
      timeout_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst   <= (state_d == PLL_RST);
      sys_reset <= (state_d != RUN);
      ready     <= (state_d == RUN);
      if (relock_inc && (relock_count != 8'hFF)) relock_count <= relock_count + 8'd1;
      if (timeout_set) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters.
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       pll_reset_req;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic [7:0] relock_count;
  logic       timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  pll_lock_supervisor #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .STABLE_CYCLES(8),
    .CNT_W        (17)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .locked       (locked),
    .pll_reset_req(pll_reset_req),
    .pll_rst      (pll_rst),
    .sys_reset    (sys_reset),
    .ready        (ready),
    .relock_count (relock_count),
    .timeout_err  (timeout_err)
  );

  always #10 refclk = ~refclk;

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int bound, input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    chk(tag, 32'(ready), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"},   32'(pll_rst),      32'd1);
    chk({tag, "_sys_reset"}, 32'(sys_reset),    32'd1);
    chk({tag, "_ready"},     32'(ready),        32'd0);
    chk({tag, "_relock"},    32'(relock_count), 32'd0);
    chk({tag, "_timeout"},   32'(timeout_err),  32'd0);
  endtask

  // Release with locked low, lock rises before edge 10; RUN reached at edge 20
  task automatic seq_basic(input string tag);
    locked = 1'b0;
    rst_n  = 1'b0;
    step();
    step();
    chk_reset_vals({tag, "_rst"});
    rst_n = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      if (e == 10) locked = 1'b1;
      step();
      chk($sformatf("%s_pll_rst_e%0d", tag, e),   32'(pll_rst),   32'(e < 4));
      chk($sformatf("%s_sys_reset_e%0d", tag, e), 32'(sys_reset), 32'(e < 20));
      chk($sformatf("%s_ready_e%0d", tag, e),     32'(ready),     32'(e >= 20));
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    locked        = 1'b0;
    pll_reset_req = 1'b0;
    #5;

    // Test 1: basic bring-up
    seq_basic("t1");

    // Test 2: lock never arrives, PLL re-pulsed every 36 cycles
    locked = 1'b0;
    rst_n  = 1'b0;
    step();
    step();
    chk_reset_vals("t2_rst");
    rst_n = 1'b1;
    for (int e = 1; e <= 80; e++) begin
      step();
      chk($sformatf("t2_pll_rst_e%0d", e), 32'(pll_rst),
          32'((e < 4) || (e >= 36 && e < 40) || (e >= 72 && e < 76)));
      chk($sformatf("t2_timeout_e%0d", e), 32'(timeout_err), 32'(e >= 36));
      chk($sformatf("t2_sys_reset_e%0d", e), 32'(sys_reset), 32'd1);
    end
    locked = 1'b1;
    wait_ready(40, "t2_reach_run");
    chk("t2_timeout_sticky_run", 32'(timeout_err), 32'd1);

    // Test 3: 3-cycle lock glitch in STABLE at counter 5
    locked = 1'b1;
    rst_n  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      if (e == 9)  locked = 1'b0;
      if (e == 12) locked = 1'b1;
      step();
      chk($sformatf("t3_pll_rst_e%0d", e),   32'(pll_rst),   32'(e < 4));
      chk($sformatf("t3_sys_reset_e%0d", e), 32'(sys_reset), 32'(e < 22));
    end
    chk("t3_relock", 32'(relock_count), 32'd0);
    chk("t3_timeout", 32'(timeout_err), 32'd0);

    // Test 4: lock loss in RUN, third edge reasserts resets
    locked = 1'b0;
    step();
    chk("t4_sys_reset_e1", 32'(sys_reset), 32'd0);
    step();
    chk("t4_sys_reset_e2", 32'(sys_reset), 32'd0);
    step();
    chk("t4_sys_reset_e3", 32'(sys_reset), 32'd1);
    chk("t4_pll_rst_e3",   32'(pll_rst),   32'd1);
    chk("t4_relock_1",     32'(relock_count), 32'd1);
    locked = 1'b1;
    wait_ready(40, "t4_relock_run");

    // Test 5: request coincident with lock loss is not counted
    locked        = 1'b0;
    pll_reset_req = 1'b1;
    step();
    pll_reset_req = 1'b0;
    chk("t5_pll_rst",   32'(pll_rst),      32'd1);
    chk("t5_sys_reset", 32'(sys_reset),    32'd1);
    chk("t5_ready",     32'(ready),        32'd0);
    chk("t5_relock",    32'(relock_count), 32'd1);
    step();
    step();
    chk("t5_relock_after", 32'(relock_count), 32'd1);
    locked = 1'b1;
    wait_ready(40, "t5_run");

    // Test 4 continued: repeated losses saturate the counter
    for (int i = 2; i <= 300; i++) begin
      locked = 1'b0;
      step();
      step();
      step();
      if (i == 2 || i == 254 || i == 255 || i == 256 || i == 300)
        chk($sformatf("t4_relock_i%0d", i), 32'(relock_count), 32'(i > 255 ? 255 : i));
      locked = 1'b1;
      wait_ready(40, $sformatf("t4_run_i%0d", i));
    end

    // Test 6: asynchronous reset in the middle of STABLE
    pll_reset_req = 1'b1;
    step();
    pll_reset_req = 1'b0;
    for (int k = 0; k < 7; k++) step();
    chk("t6_mid_stable_sys_reset", 32'(sys_reset), 32'd1);
    chk("t6_mid_stable_pll_rst",   32'(pll_rst),   32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t6_async");
    seq_basic("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
